// File: rtl/mem_dma_pkg.sv
// Shared definitions for the memory DMA block: width defaults, state
// encoding and a small state-classification helper.
package mem_dma_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // True in the states that own the RAM port.
  function automatic logic is_xfer(input state_e s);
    return (s == ST_READ) || (s == ST_WRITE);
  endfunction

endpackage

// File: rtl/mem_dma.sv
// Word-at-a-time DMA engine on RAM port B: copies src->dst (READ/WRITE per
// word) or fills dst with a constant (one WRITE per word).
module mem_dma
  import mem_dma_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              fill,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] len,
  input  logic [DATA_W-1:0] fill_value,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_enable,
  input  logic [DATA_W-1:0] mem_read_data
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   src_ptr_q, src_ptr_d;
  logic [ADDR_W-1:0]   dst_ptr_q, dst_ptr_d;
  logic [ADDR_W-1:0]   remaining_q, remaining_d;
  logic                fill_q, fill_d;
  logic [DATA_W-1:0]   fill_value_q, fill_value_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [DATA_W-1:0]   mem_write_data_q, mem_write_data_d;
  logic                mem_write_enable_q, mem_write_enable_d;

  // Next-state and next-output logic; outputs are derived from state_d so the
  // registered port values line up with the state they belong to.
  always_comb begin
    state_d      = state_q;
    src_ptr_d    = src_ptr_q;
    dst_ptr_d    = dst_ptr_q;
    remaining_d  = remaining_q;
    fill_d       = fill_q;
    fill_value_d = fill_value_q;
    data_d       = data_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len != {ADDR_W{1'b0}}) begin
            src_ptr_d    = src;
            dst_ptr_d    = dst;
            remaining_d  = len;
            fill_d       = fill;
            fill_value_d = fill_value;
            state_d      = fill ? ST_WRITE : ST_READ;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        // RAM presented the word on the falling edge of this cycle.
        data_d  = mem_read_data;
        state_d = abort ? ST_DONE : ST_WRITE;
      end
      ST_WRITE: begin
        src_ptr_d   = src_ptr_q + ADDR_W'(1);
        dst_ptr_d   = dst_ptr_q + ADDR_W'(1);
        remaining_d = remaining_q - ADDR_W'(1);
        if (abort || (remaining_q == ADDR_W'(1))) begin
          state_d = ST_DONE;
        end else if (fill_q) begin
          state_d = ST_WRITE;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d             = (state_d != ST_IDLE);
    done_d             = (state_d == ST_DONE);
    mem_write_enable_d = (state_d == ST_WRITE);

    case (state_d)
      ST_READ:  mem_address_d = src_ptr_d;
      ST_WRITE: mem_address_d = dst_ptr_d;
      default:  mem_address_d = {ADDR_W{1'b0}};
    endcase

    if (state_d == ST_WRITE) begin
      mem_write_data_d = fill_d ? fill_value_d : data_d;
    end else begin
      mem_write_data_d = {DATA_W{1'b0}};
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q            <= ST_IDLE;
      src_ptr_q          <= {ADDR_W{1'b0}};
      dst_ptr_q          <= {ADDR_W{1'b0}};
      remaining_q        <= {ADDR_W{1'b0}};
      fill_q             <= 1'b0;
      fill_value_q       <= {DATA_W{1'b0}};
      data_q             <= {DATA_W{1'b0}};
      busy_q             <= 1'b0;
      done_q             <= 1'b0;
      mem_address_q      <= {ADDR_W{1'b0}};
      mem_write_data_q   <= {DATA_W{1'b0}};
      mem_write_enable_q <= 1'b0;
    end else begin
      state_q            <= state_d;
      src_ptr_q          <= src_ptr_d;
      dst_ptr_q          <= dst_ptr_d;
      remaining_q        <= remaining_d;
      fill_q             <= fill_d;
      fill_value_q       <= fill_value_d;
      data_q             <= data_d;
      busy_q             <= busy_d;
      done_q             <= done_d;
      mem_address_q      <= mem_address_d;
      mem_write_data_q   <= mem_write_data_d;
      mem_write_enable_q <= mem_write_enable_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign mem_address      = mem_address_q;
  assign mem_write_data   = mem_write_data_q;
  assign mem_write_enable = mem_write_enable_q;

endmodule

// File: tb/tb_mem_dma.sv
// Directed bench for mem_dma with a behavioural port-B RAM (read registered on
// the falling edge, write on the rising edge).
module tb_mem_dma;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        fill;
  logic [15:0] src;
  logic [15:0] dst;
  logic [15:0] len;
  logic [15:0] fill_value;
  logic        abort;
  logic        busy;
  logic        done;
  logic [15:0] mem_address;
  logic [15:0] mem_write_data;
  logic        mem_write_enable;
  logic [15:0] mem_read_data;

  logic [15:0] ram [0:65535];

  int err_cnt = 0;
  int chk_cnt = 0;
  int wr_cnt;
  int done_cnt;
  int busy_cnt;
  int done_at;
  logic [15:0] rd_log[$];
  logic [15:0] wr_log[$];

  mem_dma dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .fill             (fill),
    .src              (src),
    .dst              (dst),
    .len              (len),
    .fill_value       (fill_value),
    .abort            (abort),
    .busy             (busy),
    .done             (done),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_data    (mem_read_data)
  );

  always #5 clock = ~clock;

  always @(negedge clock) mem_read_data <= ram[mem_address];
  always @(posedge clock) if (mem_write_enable) ram[mem_address] <= mem_write_data;

  // Mid-cycle monitor of port activity.
  always @(negedge clock) begin
    if (mem_write_enable) begin
      wr_cnt = wr_cnt + 1;
      wr_log.push_back(mem_address);
    end
    if (busy && !mem_write_enable && !done) rd_log.push_back(mem_address);
    if (done) done_cnt = done_cnt + 1;
    if (busy) busy_cnt = busy_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt = chk_cnt + 1;
    if (got !== exp) begin
      err_cnt = err_cnt + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    wr_cnt   = 0;
    done_cnt = 0;
    busy_cnt = 0;
    rd_log.delete();
    wr_log.delete();
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Launch a transfer and count cycles until done; optional abort and a
  // stray start request while busy.
  task automatic do_xfer(input logic f, input logic [15:0] s, input logic [15:0] d,
                         input logic [15:0] l, input logic [15:0] fv,
                         input int abort_cyc, input logic poke);
    clear_mon();
    start = 1'b1; fill = f; src = s; dst = d; len = l; fill_value = fv;
    next_cycle();
    start   = 1'b0;
    done_at = 0;
    for (int n = 1; n <= 40; n++) begin
      abort = (n == abort_cyc);
      if (poke && n == 2) begin
        start = 1'b1; fill = 1'b1; dst = 16'h7000; len = 16'd1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        done_at = n;
        abort   = 1'b0;
        start   = 1'b0;
        break;
      end
      next_cycle();
    end
    abort = 1'b0;
    start = 1'b0;
    next_cycle();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; fill = 1'b0; abort = 1'b0;
    src = 16'h0000; dst = 16'h0000; len = 16'h0000; fill_value = 16'h0000;
    ram[16'h0010] = 16'hAAAA; ram[16'h0011] = 16'hBBBB; ram[16'h0012] = 16'hCCCC;
    ram[16'hFFFE] = 16'h1111; ram[16'hFFFF] = 16'h2222;
    ram[16'h0000] = 16'h3333; ram[16'h0001] = 16'h4444;
    ram[16'h0204] = 16'h1234; ram[16'h0402] = 16'hBEEF; ram[16'h7000] = 16'h7777;
    clear_mon();
    next_cycle();
    next_cycle();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_we", mem_write_enable, 1'b0);
    check("rst_addr", mem_address, 16'h0000);
    check("rst_wdata", mem_write_data, 16'h0000);
    reset = 1'b1;
    next_cycle();

    // Copy of three words.
    do_xfer(1'b0, 16'h0010, 16'h0100, 16'd3, 16'h0000, 0, 1'b0);
    check("copy_done_at", done_at, 7);
    check("copy_busy_cycles", busy_cnt, 7);
    check("copy_done_pulses", done_cnt, 1);
    check("copy_writes", wr_cnt, 3);
    check("copy_w0", ram[16'h0100], 16'hAAAA);
    check("copy_w1", ram[16'h0101], 16'hBBBB);
    check("copy_w2", ram[16'h0102], 16'hCCCC);
    check("copy_idle_busy", busy, 1'b0);

    // Fill of four words, with a start request ignored while busy.
    do_xfer(1'b1, 16'h0000, 16'h0200, 16'd4, 16'h5A5A, 0, 1'b1);
    check("fill_done_at", done_at, 5);
    check("fill_writes", wr_cnt, 4);
    for (int i = 0; i < 4; i++) check("fill_word", ram[16'h0200 + i[15:0]], 16'h5A5A);
    check("fill_past_end", ram[16'h0204], 16'h1234);
    check("fill_busy_start_ignored", ram[16'h7000], 16'h7777);

    // Zero-length request.
    do_xfer(1'b0, 16'h0010, 16'h0800, 16'd0, 16'h0000, 0, 1'b0);
    check("len0_done_at", done_at, 1);
    check("len0_writes", wr_cnt, 0);
    check("len0_busy_cycles", busy_cnt, 1);

    // Copy across the top of the address space.
    do_xfer(1'b0, 16'hFFFE, 16'h0300, 16'd4, 16'h0000, 0, 1'b0);
    check("wrap_done_at", done_at, 9);
    check("wrap_reads", rd_log.size(), 4);
    check("wrap_writes", wr_log.size(), 4);
    if (rd_log.size() == 4 && wr_log.size() == 4) begin
      check("wrap_rd0", rd_log[0], 16'hFFFE);
      check("wrap_rd1", rd_log[1], 16'hFFFF);
      check("wrap_rd2", rd_log[2], 16'h0000);
      check("wrap_rd3", rd_log[3], 16'h0001);
      check("wrap_wr0", wr_log[0], 16'h0300);
      check("wrap_wr3", wr_log[3], 16'h0303);
    end
    check("wrap_d0", ram[16'h0300], 16'h1111);
    check("wrap_d1", ram[16'h0301], 16'h2222);
    check("wrap_d2", ram[16'h0302], 16'h3333);
    check("wrap_d3", ram[16'h0303], 16'h4444);

    // Abort in the second WRITE of a five-word fill.
    do_xfer(1'b1, 16'h0000, 16'h0400, 16'd5, 16'hC3C3, 2, 1'b0);
    check("abort_done_at", done_at, 3);
    check("abort_writes", wr_cnt, 2);
    check("abort_done_pulses", done_cnt, 1);
    check("abort_busy_after", busy, 1'b0);
    check("abort_w1", ram[16'h0401], 16'hC3C3);
    check("abort_untouched", ram[16'h0402], 16'hBEEF);

    // Reset during the first WRITE of a copy.
    clear_mon();
    start = 1'b1; fill = 1'b0; src = 16'h0010; dst = 16'h0500; len = 16'd3;
    next_cycle();
    start = 1'b0;
    next_cycle();
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
    check("mid_rst_we", mem_write_enable, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    for (int i = 0; i < 6; i++) next_cycle();
    check("mid_rst_no_done", done_cnt, 0);
    check("mid_rst_writes", wr_cnt, 1);
    do_xfer(1'b1, 16'h0000, 16'h0600, 16'd2, 16'h0F0F, 0, 1'b0);
    check("post_rst_done_at", done_at, 3);
    check("post_rst_w1", ram[16'h0601], 16'h0F0F);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
